// File: rtl/common_pseudo_lru_alloc.sv
// common_pseudo_lru_alloc
//   Victim allocator for small fully-associative tables. Tracks a valid bit per slot
//   and a heap-ordered tree pseudo-LRU. Each accepted request returns one slot one
//   cycle later. The slot is the lowest-index free slot when one exists, otherwise the
//   PLRU victim (flagged by rsp_evict). Hit touches and frees from the client keep the
//   state current. flush clears everything and blocks new requests.
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   req_valid / req_ready   allocation handshake (req_ready = !flush)
//   rsp_valid/addr/evict    registered response, one cycle after accept
//   touch_en / touch_addr   hit touch (ignored for free slots)
//   free_en / free_addr     invalidate a slot
//   flush                   synchronous clear of valid bits and tree
//   occupancy, full         registered valid-slot count and occupancy == N
module common_pseudo_lru_alloc #(
    parameter int SUBJECT_COUNT_LOG2 = 5
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         req_valid,
    output logic                         req_ready,
    output logic                         rsp_valid,
    output logic [SUBJECT_COUNT_LOG2-1:0] rsp_addr,
    output logic                         rsp_evict,
    input  logic                         touch_en,
    input  logic [SUBJECT_COUNT_LOG2-1:0] touch_addr,
    input  logic                         free_en,
    input  logic [SUBJECT_COUNT_LOG2-1:0] free_addr,
    input  logic                         flush,
    output logic [SUBJECT_COUNT_LOG2:0]   occupancy,
    output logic                         full
);
    localparam int L = SUBJECT_COUNT_LOG2;
    localparam int N = 1 << L;

    // Tree nodes 1..N-1 (heap order). Bit 0 = victim lies in the lower-index half.
    logic [N-1:1] r_tree;
    logic [N-1:0] r_valid;
    logic         r_rsp_valid;
    logic [L-1:0] r_rsp_addr;
    logic         r_rsp_evict;
    logic [L:0]   r_occupancy;
    logic         r_full;

    logic         w_accept;
    logic         w_has_free;
    logic [L-1:0] w_free_idx;
    logic [L-1:0] w_pick;
    logic         w_evict;
    logic         w_eff_free;
    logic [N-1:1] w_tree_nxt;
    logic [N-1:0] w_valid_nxt;
    logic [L:0]   w_occ_nxt;

    // Point every node on slot s's root path away from s.
    function automatic logic [N-1:1] f_touch(input logic [N-1:1] t, input logic [L-1:0] s);
        logic [N-1:1] res;
        logic [L:0]   node;
        res  = t;
        node = {{L{1'b0}}, 1'b1};
        for (int lvl = 0; lvl < L; lvl++) begin
            res[node[L-1:0]] = ~s[L-1-lvl];
            node = {node[L-1:0], s[L-1-lvl]};
        end
        return res;
    endfunction

    // Walk from the root following node bits; the leaf index is the low L bits.
    function automatic logic [L-1:0] f_victim(input logic [N-1:1] t);
        logic [L:0] node;
        node = {{L{1'b0}}, 1'b1};
        for (int lvl = 0; lvl < L; lvl++) begin
            node = {node[L-1:0], t[node[L-1:0]]};
        end
        return node[L-1:0];
    endfunction

    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = L'(i);
            end
        end
    end

    assign req_ready = ~flush;
    assign w_accept  = req_valid & ~flush;
    assign w_pick    = w_has_free ? w_free_idx : f_victim(r_tree);
    assign w_evict   = ~w_has_free;

    // A free aimed at the slot being re-allocated this edge loses to the allocation.
    assign w_eff_free = free_en & r_valid[free_addr] & ~(w_accept & (free_addr == w_pick));

    // Order within one edge: hit touch, then free, then the allocation's update.
    always_comb begin
        w_tree_nxt  = r_tree;
        w_valid_nxt = r_valid;
        if (touch_en && r_valid[touch_addr])
            w_tree_nxt = f_touch(w_tree_nxt, touch_addr);
        if (free_en)
            w_valid_nxt[free_addr] = 1'b0;
        if (w_accept) begin
            w_valid_nxt[w_pick] = 1'b1;
            w_tree_nxt          = f_touch(w_tree_nxt, w_pick);
        end
        if (flush) begin
            w_tree_nxt  = '0;
            w_valid_nxt = '0;
        end
    end

    always_comb begin
        w_occ_nxt = r_occupancy;
        if (flush)
            w_occ_nxt = '0;
        else if ((w_accept && !w_evict) && !w_eff_free)
            w_occ_nxt = r_occupancy + {{L{1'b0}}, 1'b1};
        else if (!(w_accept && !w_evict) && w_eff_free)
            w_occ_nxt = r_occupancy - {{L{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tree      <= '0;
            r_valid     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_evict <= 1'b0;
            r_occupancy <= '0;
            r_full      <= 1'b0;
        end else begin
            r_tree      <= w_tree_nxt;
            r_valid     <= w_valid_nxt;
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_addr  <= w_pick;
                r_rsp_evict <= w_evict;
            end
            r_occupancy <= w_occ_nxt;
            // Occupancy never exceeds N, so its MSB alone marks full.
            r_full      <= w_occ_nxt[L];
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_evict = r_rsp_evict;
    assign occupancy = r_occupancy;
    assign full      = r_full;
endmodule

// File: tb/tb_common_pseudo_lru_alloc.sv
module tb_common_pseudo_lru_alloc;
    logic       clk, resetn;
    logic       req_valid, req_ready, rsp_valid, rsp_evict;
    logic [1:0] rsp_addr, touch_addr, free_addr;
    logic       touch_en, free_en, flush, full;
    logic [2:0] occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    common_pseudo_lru_alloc #(.SUBJECT_COUNT_LOG2(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_evict(rsp_evict),
        .touch_en(touch_en), .touch_addr(touch_addr),
        .free_en(free_en), .free_addr(free_addr),
        .flush(flush), .occupancy(occupancy), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       tch;
        logic [1:0] ta;
        logic       fr;
        logic [1:0] fa;
        logic       fl;
        logic       e_vld;
        logic [1:0] e_addr;
        logic       e_ev;
        logic [2:0] e_occ;
        logic       e_full;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(logic req, logic tch, logic [1:0] ta, logic fr, logic [1:0] fa,
                                logic fl, logic ev_vld, logic [1:0] ea, logic eev,
                                logic [2:0] eocc, logic efull);
        vec_t v;
        v.req = req; v.tch = tch; v.ta = ta; v.fr = fr; v.fa = fa; v.fl = fl;
        v.e_vld = ev_vld; v.e_addr = ea; v.e_ev = eev; v.e_occ = eocc; v.e_full = efull;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 0; touch_en = 0; touch_addr = 0; free_en = 0; free_addr = 0; flush = 0;
    endtask

    initial begin
        //          req tch ta fr fa fl | vld addr ev occ full
        vt[0]  = mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0);  // fill from empty
        vt[1]  = mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 2, 0);
        vt[2]  = mk(1, 0, 0, 0, 0, 0,   1, 2, 0, 3, 0);
        vt[3]  = mk(1, 0, 0, 0, 0, 0,   1, 3, 0, 4, 1);
        vt[4]  = mk(1, 0, 0, 0, 0, 0,   1, 0, 1, 4, 1);  // full, tree 000 -> victim 0
        vt[5]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 4, 1);  // touch 0
        vt[6]  = mk(1, 0, 0, 0, 0, 0,   1, 2, 1, 4, 1);  // victim 2
        vt[7]  = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 3, 0);  // free 1
        vt[8]  = mk(0, 1, 1, 0, 0, 0,   0, 0, 0, 3, 0);  // touch freed slot: ignored
        vt[9]  = mk(1, 0, 0, 0, 0, 0,   1, 1, 0, 4, 1);  // free slot beats PLRU
        vt[10] = mk(1, 0, 0, 0, 0, 0,   1, 3, 1, 4, 1);  // victim 3
        vt[11] = mk(1, 0, 0, 1, 3, 0,   1, 0, 1, 3, 0);  // free 3 + req: 3 not visible yet
        vt[12] = mk(1, 0, 0, 0, 0, 0,   1, 3, 0, 4, 1);  // now 3 is free
        vt[13] = mk(1, 1, 2, 0, 0, 0,   1, 1, 1, 4, 1);  // touch 2 + alloc 1: alloc wins root
        vt[14] = mk(1, 0, 0, 0, 0, 0,   1, 3, 1, 4, 1);
        vt[15] = mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);  // flush with request
        vt[16] = mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0);
        vt[17] = mk(0, 0, 0, 1, 2, 0,   0, 0, 0, 1, 0);  // free invalid slot: no-op
        vt[18] = mk(0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // touch + free same slot
        vt[19] = mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0);

        idle_inputs();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_addr", rsp_addr, 0);
        chk("reset rsp_evict", rsp_evict, 0);
        chk("reset occupancy", occupancy, 0);
        chk("reset full", full, 0);
        chk("reset req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            req_valid = vt[i].req; touch_en = vt[i].tch; touch_addr = vt[i].ta;
            free_en = vt[i].fr; free_addr = vt[i].fa; flush = vt[i].fl;
            #1;
            chk($sformatf("v%0d req_ready", i), req_ready, !vt[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rsp_valid", i), rsp_valid, vt[i].e_vld);
            if (vt[i].e_vld) begin
                chk($sformatf("v%0d rsp_addr", i), rsp_addr, vt[i].e_addr);
                chk($sformatf("v%0d rsp_evict", i), rsp_evict, vt[i].e_ev);
            end
            chk($sformatf("v%0d occupancy", i), occupancy, vt[i].e_occ);
            chk($sformatf("v%0d full", i), full, vt[i].e_full);
        end

        // Reset pulse in the middle of a request stream.
        idle_inputs();
        req_valid = 1;
        @(posedge clk);
        #1;
        chk("mid rsp_valid", rsp_valid, 1);
        chk("mid rsp_addr", rsp_addr, 1);
        chk("mid occupancy", occupancy, 2);
        #2 resetn = 1'b0;
        #1;
        chk("async rsp_valid", rsp_valid, 0);
        chk("async rsp_addr", rsp_addr, 0);
        chk("async rsp_evict", rsp_evict, 0);
        chk("async occupancy", occupancy, 0);
        chk("async full", full, 0);
        @(posedge clk);
        #1;
        chk("dropped rsp_valid", rsp_valid, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset rsp_valid", rsp_valid, 1);
        chk("post-reset rsp_addr", rsp_addr, 0);
        chk("post-reset rsp_evict", rsp_evict, 0);
        chk("post-reset occupancy", occupancy, 1);
        req_valid = 0;
        @(posedge clk);
        #1;
        chk("idle rsp_valid", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
